pinball_game_ctrl: RTL and testbench

PINBALL_GAME_CTRL -- requirements
Module: pinball_game_ctrl

---
 rtl/pinball_game_ctrl_pkg.sv | 20 ++
 rtl/pinball_group_timer.sv | 39 +++
 rtl/pinball_game_ctrl.sv | 112 +++++++++++
 tb/tb_pinball_game_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pinball_game_ctrl_pkg.sv
// Shared definitions for the pinball game controller and its scorer.
// Holds the game-state encoding and small helpers used by both.
package pinball_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam int unsigned NUM_GROUPS = 8;

    // Ball count decrement that saturates at zero.
    function automatic logic [2:0] dec_sat(input logic [2:0] value);
        return (value == '0) ? value : value - 3'd1;
    endfunction

endpackage

// File: rtl/pinball_group_timer.sv
// Scoring-group rotation: a GROUP_PERIOD-cycle counter that advances the
// active group modulo 8 each time it wraps.
module pinball_group_timer #(
    parameter int unsigned GROUP_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       restart,
    input  logic       clear,
    output logic       tick,
    output logic [2:0] group
);

    localparam int unsigned CW = $clog2(GROUP_PERIOD);

    logic [CW-1:0] count;

    assign tick = enable && (count == CW'(GROUP_PERIOD - 1));

    // restart outranks tick: a wrap coinciding with a capture is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            group <= '0;
        end else if (clear) begin
            count <= '0;
            group <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
            group <= group + 3'd1;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: ball accounting, hole capture, group rotation,
// end-of-game hold and high-score tracking.
module pinball_game_ctrl
    import pinball_game_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BALLS    = 3,
    parameter int unsigned GROUP_PERIOD = 16,
    parameter int unsigned OVER_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic [7:0]  hole_hit,
    input  logic        drain,
    input  logic [14:0] score,
    output logic [2:0]  state,
    output logic [2:0]  selected_group,
    output logic [7:0]  getball,
    output logic [2:0]  balls_left,
    output logic [14:0] high_score
);

    localparam int unsigned OW = (OVER_CYCLES > 1) ? $clog2(OVER_CYCLES) : 1;

    game_state_t cur, nxt;
    logic [2:0]    balls_nxt;
    logic [7:0]    getball_nxt;
    logic [14:0]   high_nxt;
    logic [OW-1:0] over_cnt, over_nxt;
    logic          t_enable, t_restart, t_clear;
    logic          rot_tick_unused;

    assign state    = cur;
    assign t_enable = (cur == ST_START);

    pinball_group_timer #(
        .GROUP_PERIOD(GROUP_PERIOD)
    ) u_group_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (t_enable),
        .restart(t_restart),
        .clear  (t_clear),
        .tick   (rot_tick_unused),
        .group  (selected_group)
    );

    always_comb begin
        nxt         = cur;
        balls_nxt   = balls_left;
        getball_nxt = getball;
        high_nxt    = high_score;
        over_nxt    = over_cnt;
        t_restart   = 1'b0;
        t_clear     = 1'b0;
        case (cur)
            ST_RESET: nxt = ST_WAIT;
            ST_WAIT: begin
                if (start_btn) begin
                    nxt         = ST_START;
                    balls_nxt   = 3'(NUM_BALLS);
                    getball_nxt = '0;
                    t_clear     = 1'b1;
                end
            end
            ST_START: begin
                if (hole_hit != '0) begin
                    nxt         = ST_GET;
                    getball_nxt = hole_hit;
                    t_restart   = 1'b1;
                end else if (drain) begin
                    balls_nxt = dec_sat(balls_left);
                    nxt       = (balls_left <= 3'd1) ? ST_OVER : ST_START;
                end
            end
            ST_GET: begin
                balls_nxt = dec_sat(balls_left);
                nxt       = (balls_left <= 3'd1) ? ST_OVER : ST_START;
            end
            ST_OVER: begin
                // Score is only valid in the first OVER cycle.
                if (over_cnt == '0 && score > high_score)
                    high_nxt = score;
                if (over_cnt == OW'(OVER_CYCLES - 1)) begin
                    nxt         = ST_WAIT;
                    over_nxt    = '0;
                    getball_nxt = '0;
                end else begin
                    over_nxt = over_cnt + OW'(1);
                end
            end
            default: nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= ST_RESET;
            balls_left <= '0;
            getball    <= '0;
            high_score <= '0;
            over_cnt   <= '0;
        end else begin
            cur        <= nxt;
            balls_left <= balls_nxt;
            getball    <= getball_nxt;
            high_score <= high_nxt;
            over_cnt   <= over_nxt;
        end
    end

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Scoreboard bench for pinball_game_ctrl: a game-level reference model queues
// the expected outputs of every cycle and a monitor compares them.
module tb_pinball_game_ctrl;

    localparam int NB = 3;
    localparam int GP = 16;
    localparam int OC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0;
    logic [7:0]  hole_hit = '0;
    logic        drain = 1'b0;
    logic [14:0] score = '0;
    logic [2:0]  state, selected_group, balls_left;
    logic [7:0]  getball;
    logic [14:0] high_score;

    pinball_game_ctrl #(
        .NUM_BALLS(NB),
        .GROUP_PERIOD(GP),
        .OVER_CYCLES(OC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_btn(start_btn),
        .hole_hit(hole_hit),
        .drain(drain),
        .score(score),
        .state(state),
        .selected_group(selected_group),
        .getball(getball),
        .balls_left(balls_left),
        .high_score(high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int grp;
        int gb;
        int bl;
        int hs;
    } snap_t;

    snap_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: phase, balls, captured pattern, best score, and the
    // group expressed as base + elapsed START cycles / period.
    int m_st = 0, m_bl = 0, m_gb = 0, m_hs = 0, m_run = 0, m_base = 0, m_over = 0;

    function automatic int m_group();
        return (m_base + m_run / GP) % 8;
    endfunction

    function automatic snap_t snap();
        snap_t s;
        s.st = m_st; s.grp = m_group(); s.gb = m_gb; s.bl = m_bl; s.hs = m_hs;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lose_ball();
        if (m_bl > 0) m_bl--;
        if (m_bl == 0) begin
            m_st = 4;
            m_over = OC;
        end else begin
            m_st = 2;
        end
    endtask

    task automatic model_step();
        case (m_st)
            0: m_st = 1;
            1: if (start_btn) begin
                m_st = 2; m_bl = NB; m_gb = 0; m_base = 0; m_run = 0;
            end
            2: if (hole_hit != 0) begin
                m_base = m_group(); m_run = 0; m_gb = int'(hole_hit); m_st = 3;
            end else begin
                m_run++;
                if (drain) lose_ball();
            end
            3: lose_ball();
            4: begin
                if (m_over == OC && int'(score) > m_hs) m_hs = int'(score);
                m_over--;
                if (m_over == 0) begin
                    m_st = 1; m_gb = 0;
                end
            end
            default: m_st = 0;
        endcase
    endtask

    // A reset arriving mid-cycle rewrites the pending expectation.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_bl = 0; m_gb = 0; m_hs = 0; m_run = 0; m_base = 0; m_over = 0;
            if (q.size() == 0) q.push_back(snap());
            else q[$] = snap();
        end else begin
            model_step();
            q.push_back(snap());
        end
    end

    always @(negedge clk) begin
        snap_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("state", 32'(state), e.st);
            check("selected_group", 32'(selected_group), e.grp);
            check("getball", 32'(getball), e.gb);
            check("balls_left", 32'(balls_left), e.bl);
            check("high_score", 32'(high_score), e.hs);
        end
    end

    task automatic cycle(input logic s, input logic [7:0] h, input logic d);
        start_btn = s; hole_hit = h; drain = d;
        @(posedge clk);
        #1;
        start_btn = 1'b0; hole_hit = '0; drain = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("dir_reset_state", 32'(state), 0);
        cycle(0, 8'h00, 0);
        check("dir_wait_state", 32'(state), 1);
        cycle(1, 8'h00, 0);
        check("dir_start_state", 32'(state), 2);
        check("dir_start_balls", 32'(balls_left), 3);

        repeat (40) cycle(0, 8'h00, 0);
        check("dir_group_after_40", 32'(selected_group), 2);
        repeat (88) cycle(0, 8'h00, 0);
        check("dir_group_wrap", 32'(selected_group), 0);
        repeat (48) cycle(0, 8'h00, 0);
        check("dir_group_3", 32'(selected_group), 3);

        cycle(0, 8'h20, 0);
        check("dir_get_state", 32'(state), 3);
        check("dir_get_ball", 32'(getball), 32'h20);
        check("dir_get_group", 32'(selected_group), 3);
        cycle(0, 8'h00, 0);
        check("dir_after_get_state", 32'(state), 2);
        check("dir_after_get_balls", 32'(balls_left), 2);

        cycle(0, 8'h01, 1);
        check("dir_hit_drain_state", 32'(state), 3);
        cycle(0, 8'h00, 0);
        check("dir_hit_drain_balls", 32'(balls_left), 1);

        score = 15'd1000;
        cycle(0, 8'h00, 1);
        check("dir_over_state", 32'(state), 4);
        cycle(0, 8'h00, 0);
        check("dir_high_load", 32'(high_score), 1000);
        repeat (7) cycle(0, 8'h00, 0);
        check("dir_over_to_wait", 32'(state), 1);
        check("dir_wait_getball", 32'(getball), 0);

        cycle(1, 8'h00, 0);
        score = 15'd500;
        repeat (3) cycle(0, 8'h00, 1);
        check("dir_three_drains", 32'(state), 4);
        repeat (8) cycle(0, 8'h00, 0);
        check("dir_lower_game_state", 32'(state), 1);
        check("dir_lower_game_high", 32'(high_score), 1000);

        cycle(1, 8'h00, 0);
        cycle(0, 8'h80, 0);
        check("dir_get_before_rst", 32'(state), 3);
        #1 rst = 1'b1;
        #1;
        check("dir_rst_state", 32'(state), 0);
        check("dir_rst_high", 32'(high_score), 0);
        check("dir_rst_getball", 32'(getball), 0);
        check("dir_rst_balls", 32'(balls_left), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 8'h00, 0);
        check("dir_rst_release", 32'(state), 1);

        repeat (3000) begin
            score = 15'($urandom_range(0, 32767));
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                cycle(($urandom % 4) == 0,
                      (($urandom % 12) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                      ($urandom % 7) == 0);
            end
        end
        repeat (3) cycle(0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
